skinny_iter: RTL and testbench

SKINNY_ITER -- requirements
Module: skinny_iter

---
 rtl/skinny_pkg.sv | 20 ++
 rtl/skinny_iter_if.sv | 27 ++
 rtl/skinny_rc_gen.sv | 22 ++
 rtl/skinny_rnd.sv | 105 ++++++++++
 rtl/skinny_iter.sv | 120 ++++++++++++
 tb/tb_skinny_iter.sv | 300 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/skinny_pkg.sv
// Shared definitions for the iterative SKINNY-128 core: FSM encoding,
// round-constant width/step and the 16-byte block view (byte 0 = MSB).
package skinny_pkg;

    localparam int RC_W       = 6;
    localparam int DEF_TOTRND = 40;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } skinny_state_e;

    typedef logic [0:15][7:0] blk_t;

    function automatic logic [RC_W-1:0] rc_step(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_iter_if.sv
// Block-level bus of skinny_iter: input block offer, ciphertext delivery, status.
interface skinny_iter_if #(
    parameter int FULLCNT = 1
) ();
    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and the producer holds data while valid is up.
    logic                       in_valid;
    logic                       in_ready;
    logic [127:0]               pt;
    logic [64+64*FULLCNT-1:0]   tk1;
    logic [127:0]               tk2;
    logic [127:0]               tk3;
    logic                       out_valid;
    logic                       out_ready;
    logic [127:0]               ct;
    logic                       busy;

    modport master (
        output in_valid, pt, tk1, tk2, tk3, out_ready,
        input  in_ready, out_valid, ct, busy
    );

    modport slave (
        input  in_valid, pt, tk1, tk2, tk3, out_ready,
        output in_ready, out_valid, ct, busy
    );
endinterface

// File: rtl/skinny_rc_gen.sv
// Unrolls the 6-bit round-constant LFSR: slice i carries the register value
// stepped i+1 times, so one cycle can feed NUMRND rounds.
module skinny_rc_gen
    import skinny_pkg::*;
#(
    parameter int NUMRND = 8
) (
    input  logic [RC_W-1:0]        rc_i,
    output logic [RC_W*NUMRND-1:0] const_o
);

    always_comb begin
        logic [RC_W-1:0] rc_v;
        const_o = '0;
        rc_v    = rc_i;
        for (int i = 0; i < NUMRND; i++) begin
            rc_v                    = rc_step(rc_v);
            const_o[RC_W*i +: RC_W] = rc_v;
        end
    end

endmodule

// File: rtl/skinny_rnd.sv
// NUMRND unrolled SKINNY-128 rounds plus the matching TK1/TK2/TK3 schedule.
// With FULLCNT=0 only the upper half of TK1 is carried (lower half is zero).
module skinny_rnd
    import skinny_pkg::*;
#(
    parameter int NUMRND  = 8,
    parameter int FULLCNT = 1
) (
    input  logic [127:0]              state_i,
    input  logic [64+64*FULLCNT-1:0]  tk1_i,
    input  logic [127:0]              tk2_i,
    input  logic [127:0]              tk3_i,
    input  logic [RC_W*NUMRND-1:0]    const_i,
    output logic [127:0]              nextstate_o,
    output logic [127:0]              nexttweak_o,
    output logic [127:0]              nextkey_o,
    output logic [64+64*FULLCNT-1:0]  nextcnt_o
);

    function automatic logic [7:0] sbox_mix(input logic [7:0] x);
        return x ^ (~(((x >> 1) | x) >> 2) & 8'h11);
    endfunction

    function automatic logic [7:0] sbox_perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
               ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        logic [7:0] y;
        y = sbox_perm(sbox_mix(x));
        y = sbox_perm(sbox_mix(y));
        y = sbox_perm(sbox_mix(y));
        y = sbox_mix(y);
        return {y[7:3], y[1], y[2], y[0]};
    endfunction

    function automatic blk_t tk_perm(input blk_t k);
        return {k[9], k[15], k[8], k[13], k[10], k[14], k[12], k[11],
                k[0], k[1],  k[2], k[3],  k[4],  k[5],  k[6],  k[7]};
    endfunction

    function automatic blk_t tk2_lfsr(input blk_t k);
        blk_t o;
        o = k;
        for (int i = 0; i < 8; i++) o[i] = {k[i][6:0], k[i][7] ^ k[i][5]};
        return o;
    endfunction

    function automatic blk_t tk3_lfsr(input blk_t k);
        blk_t o;
        o = k;
        for (int i = 0; i < 8; i++) o[i] = {k[i][0] ^ k[i][6], k[i][7:1]};
        return o;
    endfunction

    // SubCells, AddConstants, AddRoundTweakey (rows 0-1), ShiftRows, MixColumns
    function automatic blk_t round_f(input blk_t s, input blk_t tk, input logic [RC_W-1:0] rc);
        blk_t a, b;
        for (int i = 0; i < 16; i++) a[i] = sbox8(s[i]) ^ ((i < 8) ? tk[i] : 8'h00);
        a[0] = a[0] ^ {4'h0, rc[3:0]};
        a[4] = a[4] ^ {6'h0, rc[5:4]};
        a[8] = a[8] ^ 8'h02;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[4*r+c] = a[4*r + ((c - r) & 3)];
        for (int c = 0; c < 4; c++) begin
            a[c]    = b[c] ^ b[8+c] ^ b[12+c];
            a[4+c]  = b[c];
            a[8+c]  = b[4+c] ^ b[8+c];
            a[12+c] = b[c] ^ b[8+c];
        end
        return a;
    endfunction

    logic [127:0] tk1_full;
    logic [127:0] tk1_next;

    if (FULLCNT != 0) begin : g_full_tk1
        assign tk1_full  = tk1_i;
        assign nextcnt_o = tk1_next;
    end else begin : g_half_tk1
        assign tk1_full  = {tk1_i, 64'h0};
        assign nextcnt_o = tk1_next[127:64];
    end

    always_comb begin
        blk_t s, k1, k2, k3;
        s  = state_i;
        k1 = tk1_full;
        k2 = tk2_i;
        k3 = tk3_i;
        for (int r = 0; r < NUMRND; r++) begin
            s  = round_f(s, k1 ^ k2 ^ k3, const_i[RC_W*r +: RC_W]);
            k1 = tk_perm(k1);
            k2 = tk2_lfsr(tk_perm(k2));
            k3 = tk3_lfsr(tk_perm(k3));
        end
        nextstate_o = s;
        nexttweak_o = k2;
        nextkey_o   = k3;
        tk1_next    = k1;
    end

endmodule

// File: rtl/skinny_iter.sv
// Iterative SKINNY-128 block encryptor: loads a block, runs TOTRND/NUMRND
// batches of NUMRND rounds, then holds the ciphertext until it is taken.
module skinny_iter
    import skinny_pkg::*;
#(
    parameter int NUMRND  = 8,
    parameter int FULLCNT = 1,
    parameter int TOTRND  = DEF_TOTRND
) (
    input  logic          clk,
    input  logic          rst_n,
    skinny_iter_if.slave  bus,
    output skinny_state_e dbg_state_o
);

    localparam int NB   = TOTRND / NUMRND;
    localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TK1W = 64 + 64*FULLCNT;
    localparam logic [CNTW-1:0] LAST = CNTW'(NB - 1);

    if (TOTRND % NUMRND != 0) begin : g_bad_totrnd
        $error("skinny_iter: TOTRND must be a multiple of NUMRND");
    end
    // A half-width TK1 only lands back in rows 0-1 after an even round count.
    if (FULLCNT == 0 && (NUMRND % 2) != 0) begin : g_bad_half_tk1
        $error("skinny_iter: FULLCNT=0 needs an even NUMRND");
    end

    skinny_state_e      state_q, state_d;
    logic [127:0]       st_q, st_d;
    logic [TK1W-1:0]    tk1_q, tk1_d;
    logic [127:0]       tk2_q, tk2_d;
    logic [127:0]       tk3_q, tk3_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic [RC_W*NUMRND-1:0] rc_bus;
    logic [127:0]           nxt_state, nxt_tk2, nxt_tk3;
    logic [TK1W-1:0]        nxt_tk1;

    skinny_rc_gen #(.NUMRND(NUMRND)) u_rc (
        .rc_i    (rc_q),
        .const_o (rc_bus)
    );

    skinny_rnd #(.NUMRND(NUMRND), .FULLCNT(FULLCNT)) u_rnd (
        .state_i     (st_q),
        .tk1_i       (tk1_q),
        .tk2_i       (tk2_q),
        .tk3_i       (tk3_q),
        .const_i     (rc_bus),
        .nextstate_o (nxt_state),
        .nexttweak_o (nxt_tk2),
        .nextkey_o   (nxt_tk3),
        .nextcnt_o   (nxt_tk1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            tk1_q   <= '0;
            tk2_q   <= '0;
            tk3_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            tk1_q   <= tk1_d;
            tk2_q   <= tk2_d;
            tk3_q   <= tk3_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        tk1_d   = tk1_q;
        tk2_d   = tk2_q;
        tk3_d   = tk3_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_RUN;
                    st_d    = bus.pt;
                    tk1_d   = bus.tk1;
                    tk2_d   = bus.tk2;
                    tk3_d   = bus.tk3;
                    rc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                st_d  = nxt_state;
                tk1_d = nxt_tk1;
                tk2_d = nxt_tk2;
                tk3_d = nxt_tk3;
                rc_d  = rc_bus[RC_W*NUMRND-1 -: RC_W];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.ct        = st_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_skinny_iter.sv
// Directed bench for skinny_iter: vector table against a byte-level SKINNY
// model, plus stall, back-to-back, mid-run reset and 56-round known-answer.
module tb_skinny_iter;
    import skinny_pkg::*;

    localparam int LAT   = 5;
    localparam int LAT56 = 7;
    localparam int PTAB [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    localparam logic [5:0] RC_EXP [9] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    skinny_iter_if #(.FULLCNT(1)) bus ();
    skinny_iter_if #(.FULLCNT(1)) bus56 ();
    skinny_state_e dbg, dbg56;

    skinny_iter #(.NUMRND(8), .FULLCNT(1), .TOTRND(40)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg));
    skinny_iter #(.NUMRND(8), .FULLCNT(1), .TOTRND(56)) dut56 (
        .clk(clk), .rst_n(rst_n), .bus(bus56), .dbg_state_o(dbg56));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int k = 0; k < 4; k++) begin
            y[4] = y[4] ^ ~(y[7] | y[6]);
            y[0] = y[0] ^ ~(y[3] | y[2]);
            if (k < 3) y = {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
            else       y = {y[7:3], y[1], y[2], y[0]};
        end
        return y;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k1,
                                             input logic [127:0] k2, input logic [127:0] k3,
                                             input int rounds);
        logic [7:0] s [16];
        logic [7:0] t1 [16];
        logic [7:0] t2 [16];
        logic [7:0] t3 [16];
        logic [7:0] tmp [16];
        logic [5:0] rc;
        logic [127:0] res;
        rc = 6'h00;
        for (int i = 0; i < 16; i++) begin
            s[i]  = pt[127-8*i -: 8];
            t1[i] = k1[127-8*i -: 8];
            t2[i] = k2[127-8*i -: 8];
            t3[i] = k3[127-8*i -: 8];
        end
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 16; i++) s[i] = ref_sbox(s[i]);
            rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            s[0] = s[0] ^ {4'h0, rc[3:0]};
            s[4] = s[4] ^ {6'h0, rc[5:4]};
            s[8] = s[8] ^ 8'h02;
            for (int i = 0; i < 8; i++) s[i] = s[i] ^ t1[i] ^ t2[i] ^ t3[i];
            for (int i = 0; i < 16; i++) tmp[i] = t1[PTAB[i]];
            t1 = tmp;
            for (int i = 0; i < 16; i++) tmp[i] = t2[PTAB[i]];
            t2 = tmp;
            for (int i = 0; i < 16; i++) tmp[i] = t3[PTAB[i]];
            t3 = tmp;
            for (int i = 0; i < 8; i++) begin
                t2[i] = {t2[i][6:0], t2[i][7] ^ t2[i][5]};
                t3[i] = {t3[i][0] ^ t3[i][6], t3[i][7:1]};
            end
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++)
                    tmp[4*rr+c] = s[4*rr + ((c + 4 - rr) % 4)];
            for (int c = 0; c < 4; c++) begin
                s[c]    = tmp[c] ^ tmp[8+c] ^ tmp[12+c];
                s[4+c]  = tmp[c];
                s[8+c]  = tmp[4+c] ^ tmp[8+c];
                s[12+c] = tmp[c] ^ tmp[8+c];
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] pt;
        logic [127:0] tk1;
        logic [127:0] tk2;
        logic [127:0] tk3;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];
    logic [127:0] exp_q [$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic offer(input int idx);
        bus.in_valid = 1'b1;
        bus.pt  = vecs[idx].pt;
        bus.tk1 = vecs[idx].tk1;
        bus.tk2 = vecs[idx].tk2;
        bus.tk3 = vecs[idx].tk3;
    endtask

    task automatic accept(input int idx, output int waited);
        offer(idx);
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        exp_q.push_back(vecs[idx].ct);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input string name);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.ct, e);
        end
    endtask

    task automatic set_vec(input int i, input logic [127:0] pt, input logic [127:0] k1,
                           input logic [127:0] k2, input logic [127:0] k3);
        vecs[i].pt  = pt;
        vecs[i].tk1 = k1;
        vecs[i].tk2 = k2;
        vecs[i].tk3 = k3;
        vecs[i].ct  = ref_enc(pt, k1, k2, k3, 40);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w, lat, seen;
        logic [127:0] ct56_exp;

        set_vec(0, 128'ha3994b66ad85a3459f44e92b08f550cb, 128'hdf889548cfc7ea52d296339301797449,
                   128'hab588a34a47f1ab2dfe9c8293fbea9a5, 128'hab1afac2611012cd8cef952618c3ebe8);
        set_vec(1, 128'h0, 128'h0, 128'h0, 128'h0);
        set_vec(2, {128{1'b1}}, 128'h0, 128'h0, 128'h0);
        set_vec(3, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                   128'h101112131415161718191a1b1c1d1e1f, 128'h202122232425262728292a2b2c2d2e2f);
        ct56_exp = 128'h94ecf589e2017c601b38c6346a10dcfa;

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.pt = '0; bus.tk1 = '0; bus.tk2 = '0; bus.tk3 = '0;
        bus56.in_valid = 1'b0; bus56.out_ready = 1'b1;
        bus56.pt = '0; bus56.tk1 = '0; bus56.tk2 = '0; bus56.tk3 = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ct", bus.ct, 0);
        check("rst_state", dbg, S_IDLE);
        check("rst_ct56", bus56.ct, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // vector table, first entry also checks the constant bus
        for (int i = 0; i < 4; i++) begin
            accept(i, w);
            check($sformatf("busy_v%0d", i), bus.busy, 1);
            if (i == 0) begin
                for (int j = 0; j < 8; j++)
                    check($sformatf("rc_slice%0d", j), dut.u_rc.const_o[6*j +: 6], RC_EXP[j]);
                @(negedge clk);
                check("rc_cycle2", dut.u_rc.const_o[5:0], RC_EXP[8]);
                wait_out(1, lat);
            end else begin
                wait_out(0, lat);
            end
            check($sformatf("lat_v%0d", i), lat, LAT);
            take($sformatf("ct_v%0d", i));
            @(negedge clk);
            check($sformatf("idle_after_v%0d", i), bus.out_valid, 0);
        end

        // stall: out_ready low for 20 cycles, new in_valid must be ignored
        bus.out_ready = 1'b0;
        accept(1, w);
        wait_out(0, lat);
        check("stall_lat", lat, LAT);
        offer(2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("stall_ct_%0d", k), bus.ct, vecs[1].ct);
            check($sformatf("stall_ov_%0d", k), bus.out_valid, 1);
            check($sformatf("stall_ir_%0d", k), bus.in_ready, 0);
            check($sformatf("stall_st_%0d", k), dbg, S_DONE);
        end
        bus.out_ready = 1'b1;
        take("stall_ct");
        @(negedge clk);
        accept(2, w);
        check("post_stall_wait", w, 0);
        wait_out(0, lat);
        check("post_stall_lat", lat, LAT);
        take("post_stall_ct");
        @(negedge clk);

        // back-to-back with out_ready tied high
        accept(3, w);
        wait_out(0, lat);
        check("b2b_lat_a", lat, LAT);
        take("b2b_ct_a");
        accept(0, w);
        check("b2b_gap", w, 1);
        check("b2b_period", lat + w + 1, LAT + 2);
        wait_out(0, lat);
        check("b2b_lat_b", lat, LAT);
        take("b2b_ct_b");
        @(negedge clk);

        // reset in RUN cycle 3 aborts the block
        accept(1, w);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ct", bus.ct, 0);
        check("mid_rst_state", dbg, S_IDLE);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mid_no_output", seen, 0);
        accept(3, w);
        wait_out(0, lat);
        check("mid_after_lat", lat, LAT);
        take("mid_after_ct");
        @(negedge clk);

        // 56-round known answer on the second instance
        bus56.in_valid = 1'b1;
        bus56.pt  = vecs[0].pt;
        bus56.tk1 = vecs[0].tk1;
        bus56.tk2 = vecs[0].tk2;
        bus56.tk3 = vecs[0].tk3;
        check("kat56_in_ready", bus56.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus56.in_valid = 1'b0;
        lat = 0;
        while (!bus56.out_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        check("kat56_lat", lat, LAT56);
        check("kat56_ct", bus56.ct, ct56_exp);
        @(negedge clk);
        check("kat56_released", bus56.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
